predemux_buf: RTL and testbench

One-hot-steered demultiplexer with a one-entry output register per lane. It is the write-side counterpart of `premux`: one W-bit input stream carries a pre-decoded N-bit destination mask, and the block delivers the word to every selected lane through independent valid/ready handshakes. It sits between a single producer, such as a dispatch or response stage, and N per-unit consumers whose grants are already one-hot, so no binary decode is needed on the select path.

---
 rtl/predemux_buf.sv | 70 +++++++
 tb/tb_predemux_buf.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/predemux_buf.sv
// predemux_buf: one-hot-steered demultiplexer with a one-entry output slot per lane.
// A single W-bit input stream carries a pre-decoded N-bit destination mask. Each
// accepted word is written into every selected lane at the same edge, with no
// partial multicast. Each lane then drains through its own valid/ready handshake.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    input word present
//   in_ready    input word accepted this cycle (combinational from in_sel/out_ready)
//   in_sel      N-bit destination mask; one-hot, multi-hot or zero
//   in_data     W-bit input word
//   out_valid   per-lane slot holds a word
//   out_ready   per-lane consumer accepts the word
//   out_data    lane i at bits [i*W +: W]
//   drop_count  saturating count of accepted words with an all-zero mask
module predemux_buf #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_sel,
    input  logic [W-1:0]   in_data,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic [7:0]     drop_count
);

    localparam logic [7:0] CNT_MAX = 8'hFF;

    logic [N-1:0] free;
    logic         accept;
    logic         drop;

    // A slot is free when it is empty or is draining this cycle. The input is
    // accepted only if every targeted lane can take it. That makes the accept
    // all-or-nothing, and in_valid takes no part in it.
    always_comb begin
        free     = ~out_valid | out_ready;
        in_ready = &(~in_sel | free);
        accept   = in_valid && in_ready;
        drop     = accept && (in_sel == '0);
    end

    // Lane slots: a load has priority over a drain, so a lane can drain and reload
    // at the same edge. Lane data changes only on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= '0;
            out_data   <= '0;
            drop_count <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (accept && in_sel[i]) begin
                    out_valid[i]         <= 1'b1;
                    out_data[i*W +: W]   <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i]         <= 1'b0;
                end
            end
            if (drop && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_predemux_buf.sv
// Scoreboard bench for predemux_buf (N=4, W=8): per-lane queues of expected words.
module tb_predemux_buf;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_sel;
    logic [W-1:0]   in_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
    logic [7:0]     drop_count;

    predemux_buf #(.W(W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_valid;
    logic [W-1:0] m_q [N][$];
    int           m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane(input int i);
        logic [N*W-1:0] v;
        v = out_data;
        return v[i*W +: W];
    endfunction

    // One cycle: drive, check outputs against the model, clock, then update the model.
    task automatic step(input logic v, input logic [N-1:0] sel, input logic [W-1:0] d,
                        input logic [N-1:0] ordy);
        logic [N-1:0] free;
        logic         exp_rdy;
        logic         acc;
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        free    = ~m_valid | ordy;
        exp_rdy = &(~sel | free);
        acc     = v && exp_rdy;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        for (int i = 0; i < int'(N); i++) begin
            if (m_valid[i] && m_q[i].size() > 0) begin
                check($sformatf("lane%0d_data", i), 32'(lane(i)), 32'(m_q[i][0]));
            end
        end
        @(posedge clk);
        for (int i = 0; i < int'(N); i++) begin
            if (m_valid[i] && ordy[i]) begin
                void'(m_q[i].pop_front());
                m_valid[i] = 1'b0;
            end
            if (acc && sel[i]) begin
                m_q[i].push_back(d);
                m_valid[i] = 1'b1;
            end
        end
        if (acc && sel == '0 && m_drop < 255) m_drop++;
    endtask

    // Reset for 'cycles' edges while offering a word, then check the reset state.
    task automatic do_reset(input int cycles, input logic [N-1:0] sel, input logic [W-1:0] d);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = sel;
        in_data   = d;
        out_ready = N'($urandom);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sel   = '0;
        for (int i = 0; i < int'(N); i++) m_q[i].delete();
        m_valid = '0;
        m_drop  = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
    endtask

    task automatic idle(input int n, input logic [N-1:0] ordy);
        for (int k = 0; k < n; k++) step(1'b0, N'($urandom), W'($urandom), ordy);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        m_valid   = '0;
        m_drop    = 0;

        // Reset with arbitrary inputs
        do_reset(2, 4'b1011, 8'hC3);
        idle(2, 4'b1111);

        // Unicast streaming to lane 2
        step(1'b1, 4'b0100, 8'h11, 4'b1111);
        step(1'b1, 4'b0100, 8'h22, 4'b1111);
        step(1'b1, 4'b0100, 8'h33, 4'b1111);
        idle(2, 4'b1111);

        // Multicast blocked by a stalled lane 0
        step(1'b1, 4'b0001, 8'h10, 4'b0000);
        step(1'b1, 4'b0011, 8'hAB, 4'b0000);
        step(1'b1, 4'b0011, 8'hAB, 4'b0000);
        step(1'b1, 4'b0011, 8'hAB, 4'b0001);
        step(1'b0, 4'b0000, 8'h00, 4'b0000);
        check("mc_lane0", 32'(lane(0)), 32'hAB);
        check("mc_lane1", 32'(lane(1)), 32'hAB);
        idle(2, 4'b1111);

        // Independent lanes: lane 3 stalled full, lane 0 still accepts
        step(1'b1, 4'b1000, 8'h77, 4'b0000);
        step(1'b1, 4'b0001, 8'h5A, 4'b0000);
        step(1'b0, 4'b0000, 8'h00, 4'b0000);
        check("ind_lane3", 32'(lane(3)), 32'h77);
        check("ind_lane0", 32'(lane(0)), 32'h5A);
        idle(2, 4'b1111);

        // Random multicast traffic with random backpressure
        for (int k = 0; k < 200; k++)
            step(1'($urandom), N'($urandom), W'($urandom), N'($urandom));
        idle(3, 4'b1111);

        // Zero mask: 300 dropped words, saturating counter
        for (int k = 0; k < 300; k++) step(1'b1, 4'b0000, W'(k), 4'b1111);
        step(1'b0, 4'b0000, 8'h00, 4'b1111);
        check("drop_sat", 32'(drop_count), 32'd255);

        // Reset mid-operation with a word on offer
        step(1'b1, 4'b0001, 8'hA0, 4'b0000);
        step(1'b1, 4'b0010, 8'hA1, 4'b0000);
        step(1'b1, 4'b0100, 8'hA2, 4'b0000);
        step(1'b0, 4'b0000, 8'h00, 4'b0000);
        do_reset(1, 4'b1000, 8'hEE);
        idle(2, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
